// File: rtl/bru_if.sv
// EX-to-BRU operand bus plus the redirect/flush handshake back to fetch.
// The slave modport is the branch resolution unit; the master is the pipeline side.
interface bru_if #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned PC_WIDTH = 64
);
  logic                ex_valid_i;
  logic [PC_WIDTH-1:0] ex_pc_i;
  logic                ex_jal_i;
  logic                ex_jalr_i;
  logic                ex_branch_i;
  logic [2:0]          ex_funct3_i;
  logic [XLEN-1:0]     ex_rs1_i;
  logic [XLEN-1:0]     ex_rs2_i;
  logic [XLEN-1:0]     ex_imm_i;
  logic                ex_prdt_taken_i;
  logic                redirect_ack_i;
  logic                redirect_valid_o;
  logic [PC_WIDTH-1:0] redirect_pc_o;
  logic                flush_o;

  modport slave (
    input  ex_valid_i, ex_pc_i, ex_jal_i, ex_jalr_i, ex_branch_i, ex_funct3_i,
    input  ex_rs1_i, ex_rs2_i, ex_imm_i, ex_prdt_taken_i, redirect_ack_i,
    output redirect_valid_o, redirect_pc_o, flush_o
  );

  modport master (
    output ex_valid_i, ex_pc_i, ex_jal_i, ex_jalr_i, ex_branch_i, ex_funct3_i,
    output ex_rs1_i, ex_rs2_i, ex_imm_i, ex_prdt_taken_i, redirect_ack_i,
    input  redirect_valid_o, redirect_pc_o, flush_o
  );
endinterface

// File: rtl/bru_resolve.sv
// Execute-stage branch resolution: evaluates conditions and targets, detects mispredictions
// against fetch's static prediction, and holds a redirect request until fetch acknowledges.
module bru_resolve #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned PC_WIDTH  = 64,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bru_if.slave                 bus,
  output logic [XLEN-1:0]      link_o,
  output logic                 misalign_o,
  output logic [PC_WIDTH-1:0]  misalign_tval_o,
  output logic [CNT_WIDTH-1:0] branch_cnt_o,
  output logic [CNT_WIDTH-1:0] mispred_cnt_o
);

  typedef enum logic [0:0] {StIdle, StRedirect} state_e;

  state_e state_q, state_d;

  logic                 is_jal, is_jalr, is_br;
  logic                 br_taken;
  logic [PC_WIDTH-1:0]  imm_pc, rs1_pc, seq_pc, rel_pc, jalr_sum, jalr_pc, jalr_pred;
  logic [PC_WIDTH-1:0]  target;
  logic                 mispredict, chk_align, misalign;
  logic                 acc, go_redirect;

  logic [PC_WIDTH-1:0]  redirect_pc_q, redirect_pc_d;
  logic                 flush_q, flush_d;
  logic                 misalign_q, misalign_d;
  logic [PC_WIDTH-1:0]  tval_q, tval_d;
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

  // Type priority when several flags are set: jal > jalr > branch.
  always_comb begin
    is_jal  = bus.ex_jal_i;
    is_jalr = !bus.ex_jal_i && bus.ex_jalr_i;
    is_br   = !bus.ex_jal_i && !bus.ex_jalr_i && bus.ex_branch_i;
  end

  always_comb begin
    br_taken = 1'b0;
    case (bus.ex_funct3_i)
      3'b000:  br_taken = (bus.ex_rs1_i == bus.ex_rs2_i);
      3'b001:  br_taken = (bus.ex_rs1_i != bus.ex_rs2_i);
      3'b100:  br_taken = ($signed(bus.ex_rs1_i) < $signed(bus.ex_rs2_i));
      3'b101:  br_taken = ($signed(bus.ex_rs1_i) >= $signed(bus.ex_rs2_i));
      3'b110:  br_taken = (bus.ex_rs1_i < bus.ex_rs2_i);
      3'b111:  br_taken = (bus.ex_rs1_i >= bus.ex_rs2_i);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    imm_pc    = PC_WIDTH'(bus.ex_imm_i);
    rs1_pc    = PC_WIDTH'(bus.ex_rs1_i);
    seq_pc    = bus.ex_pc_i + PC_WIDTH'(4);
    rel_pc    = bus.ex_pc_i + imm_pc;
    jalr_sum  = rs1_pc + imm_pc;
    jalr_pc   = {jalr_sum[PC_WIDTH-1:1], 1'b0};
    // Fetch follows jalr as if rs1 were zero.
    jalr_pred = {imm_pc[PC_WIDTH-1:1], 1'b0};
  end

  always_comb begin
    target     = seq_pc;
    mispredict = 1'b0;
    chk_align  = 1'b0;
    if (is_jal) begin
      target    = rel_pc;
      chk_align = 1'b1;
    end else if (is_jalr) begin
      target     = jalr_pc;
      mispredict = (jalr_pc != jalr_pred);
      chk_align  = 1'b1;
    end else if (is_br) begin
      target     = br_taken ? rel_pc : seq_pc;
      mispredict = (br_taken != bus.ex_prdt_taken_i);
      chk_align  = br_taken;
    end
    misalign = chk_align && (target[1:0] != 2'b00);
  end

  // Anything presented while a redirect is outstanding is wrong-path and dropped.
  always_comb begin
    acc         = bus.ex_valid_i && (state_q == StIdle);
    go_redirect = acc && mispredict && !misalign;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (go_redirect) state_d = StRedirect;
      StRedirect: if (bus.redirect_ack_i) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    redirect_pc_d = go_redirect ? target : redirect_pc_q;
    flush_d       = go_redirect;
    misalign_d    = acc && misalign;
    tval_d        = (acc && misalign) ? target : tval_q;

    branch_cnt_d = branch_cnt_q;
    if (acc && is_br && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
    end
    mispred_cnt_d = mispred_cnt_q;
    if (acc && mispredict && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
      tval_q        <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
      tval_q        <= tval_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.redirect_valid_o = (state_q == StRedirect);
  assign bus.redirect_pc_o    = redirect_pc_q;
  assign bus.flush_o          = flush_q;

  always_comb begin
    link_o          = XLEN'(bus.ex_pc_i + PC_WIDTH'(4));
    misalign_o      = misalign_q;
    misalign_tval_o = tval_q;
    branch_cnt_o    = branch_cnt_q;
    mispred_cnt_o   = mispred_cnt_q;
  end

endmodule

// File: tb/tb_bru_resolve.sv
// Self-checking bench for bru_resolve: directed scenarios plus randomized traffic checked
// against a transaction-level reference model.
module tb_bru_resolve;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bru_if #(.XLEN(64), .PC_WIDTH(64)) bus ();

  logic [63:0]   link;
  logic          misalign;
  logic [63:0]   tval;
  logic [CW-1:0] bcnt, mcnt;

  bru_resolve #(.XLEN(64), .PC_WIDTH(64), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .link_o          (link),
    .misalign_o      (misalign),
    .misalign_tval_o (tval),
    .branch_cnt_o    (bcnt),
    .mispred_cnt_o   (mcnt)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  bit          m_busy, m_flush, m_mis;
  logic [63:0] m_rpc, m_tval;
  int          m_bcnt, m_mcnt;

  // What the instruction means architecturally, independent of any pipeline state.
  function automatic void ref_resolve(input logic [63:0] pc, input bit jal, input bit jalr,
                                      input bit br, input logic [2:0] f3,
                                      input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] imm, input bit prdt,
                                      output logic [63:0] tgt, output bit mp, output bit mal,
                                      output bit isbr);
    bit t;
    longint sa, sb;
    tgt = pc + 64'd4; mp = 0; mal = 0; isbr = 0;
    sa = a; sb = b;
    if (jal) begin
      tgt = pc + imm;
      mal = (tgt % 4) != 0;
    end else if (jalr) begin
      tgt = (a + imm) - ((a + imm) % 2);
      mp  = tgt != (imm - (imm % 2));
      mal = (tgt % 4) != 0;
    end else if (br) begin
      isbr = 1;
      case (f3)
        3'd0: t = (a == b);
        3'd1: t = (a != b);
        3'd4: t = (sa < sb);
        3'd5: t = !(sa < sb);
        3'd6: t = (a < b);
        3'd7: t = !(a < b);
        default: t = 0;
      endcase
      tgt = t ? pc + imm : pc + 64'd4;
      mp  = (t != prdt);
      mal = t && ((tgt % 4) != 0);
    end
  endfunction

  task automatic set_ex(input bit v, input bit jal, input bit jalr, input bit br,
                        input logic [2:0] f3, input logic [63:0] pc, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] imm, input bit prdt);
    bus.ex_valid_i = v; bus.ex_jal_i = jal; bus.ex_jalr_i = jalr; bus.ex_branch_i = br;
    bus.ex_funct3_i = f3; bus.ex_pc_i = pc; bus.ex_rs1_i = a; bus.ex_rs2_i = b;
    bus.ex_imm_i = imm; bus.ex_prdt_taken_i = prdt;
  endtask

  task automatic clear_ex();
    set_ex(0, 0, 0, 0, 3'd0, 64'h0, 64'h0, 64'h0, 64'h0, 0);
  endtask

  // Advance one clock, updating the model from the inputs visible before the edge.
  task automatic tick();
    logic [63:0] tgt;
    bit mp, mal, isbr;
    ref_resolve(bus.ex_pc_i, bus.ex_jal_i, bus.ex_jalr_i, bus.ex_branch_i, bus.ex_funct3_i,
                bus.ex_rs1_i, bus.ex_rs2_i, bus.ex_imm_i, bus.ex_prdt_taken_i,
                tgt, mp, mal, isbr);
    m_flush = 0; m_mis = 0;
    if (!m_busy) begin
      if (bus.ex_valid_i) begin
        if (isbr && m_bcnt < CMAX) m_bcnt++;
        if (mp && m_mcnt < CMAX) m_mcnt++;
        if (mal) begin
          m_mis = 1; m_tval = tgt;
        end else if (mp) begin
          m_busy = 1; m_rpc = tgt; m_flush = 1;
        end
      end
    end else if (bus.redirect_ack_i) begin
      m_busy = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    m_busy = 0; m_flush = 0; m_mis = 0; m_rpc = '0; m_tval = '0; m_bcnt = 0; m_mcnt = 0;
  endtask

  task automatic do_reset();
    clear_ex();
    bus.redirect_ack_i = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (bus.redirect_valid_o !== 1'b0) $display("FAIL reset_rv got=%b exp=0", bus.redirect_valid_o); else n_pass++;
    n_total++; if (bus.redirect_pc_o !== 64'h0) $display("FAIL reset_rpc got=%h exp=0", bus.redirect_pc_o); else n_pass++;
    n_total++; if (bus.flush_o !== 1'b0) $display("FAIL reset_flush got=%b exp=0", bus.flush_o); else n_pass++;
    n_total++; if (misalign !== 1'b0 || tval !== 64'h0) $display("FAIL reset_mis got=%b/%h exp=0/0", misalign, tval); else n_pass++;
    n_total++; if (bcnt !== 0 || mcnt !== 0) $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bcnt, mcnt); else n_pass++;
  endtask

  task automatic test_beq_hit();
    set_ex(1, 0, 0, 1, 3'd0, 64'h1000, 64'd5, 64'd5, -64'sd16, 1);
    tick(); clear_ex();
    n_total++; if (bus.redirect_valid_o !== 1'b0 || bus.flush_o !== 1'b0) $display("FAIL beq_noredir got=%b/%b exp=0/0", bus.redirect_valid_o, bus.flush_o); else n_pass++;
    n_total++; if (bcnt !== 4'd1 || mcnt !== 4'd0) $display("FAIL beq_cnt got=%0d/%0d exp=1/0", bcnt, mcnt); else n_pass++;
  endtask

  task automatic test_bne_redirect();
    set_ex(1, 0, 0, 1, 3'd1, 64'h1000, 64'd7, 64'd7, -64'sd16, 1);
    tick(); clear_ex();
    n_total++; if (bus.redirect_valid_o !== 1'b1 || bus.redirect_pc_o !== 64'h1004) $display("FAIL bne_redir got=%b/%h exp=1/1004", bus.redirect_valid_o, bus.redirect_pc_o); else n_pass++;
    n_total++; if (bus.flush_o !== 1'b1) $display("FAIL bne_flush got=%b exp=1", bus.flush_o); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (bus.redirect_valid_o !== 1'b1 || bus.redirect_pc_o !== 64'h1004 || bus.flush_o !== 1'b0) $display("FAIL bne_hold%0d got=%b/%h/%b exp=1/1004/0", i, bus.redirect_valid_o, bus.redirect_pc_o, bus.flush_o); else n_pass++;
    end
    bus.redirect_ack_i = 1;
    tick();
    bus.redirect_ack_i = 0;
    n_total++; if (bus.redirect_valid_o !== 1'b0) $display("FAIL bne_ackdrop got=%b exp=0", bus.redirect_valid_o); else n_pass++;
    n_total++; if (bcnt !== 4'd2 || mcnt !== 4'd1) $display("FAIL bne_cnt got=%0d/%0d exp=2/1", bcnt, mcnt); else n_pass++;
  endtask

  task automatic test_bltu_forward();
    set_ex(1, 0, 0, 1, 3'd6, 64'h2000, 64'd1, '1, 64'h40, 0);
    tick(); clear_ex();
    n_total++; if (bus.redirect_valid_o !== 1'b1 || bus.redirect_pc_o !== 64'h2040) $display("FAIL bltu_redir got=%b/%h exp=1/2040", bus.redirect_valid_o, bus.redirect_pc_o); else n_pass++;
    n_total++; if (mcnt !== 4'd2) $display("FAIL bltu_mcnt got=%0d exp=2", mcnt); else n_pass++;
    bus.redirect_ack_i = 1;  // ack in the first valid cycle
    tick();
    bus.redirect_ack_i = 0;
    n_total++; if (bus.redirect_valid_o !== 1'b0) $display("FAIL bltu_minocc got=%b exp=0", bus.redirect_valid_o); else n_pass++;
  endtask

  task automatic test_jalr();
    set_ex(1, 0, 1, 0, 3'd0, 64'h5000, 64'h8000, 64'h0, 64'h11, 0);
    tick(); clear_ex();
    n_total++; if (bus.redirect_valid_o !== 1'b1 || bus.redirect_pc_o !== 64'h8010) $display("FAIL jalr_redir got=%b/%h exp=1/8010", bus.redirect_valid_o, bus.redirect_pc_o); else n_pass++;
    bus.redirect_ack_i = 1; tick(); bus.redirect_ack_i = 0;
    set_ex(1, 0, 1, 0, 3'd0, 64'h5000, 64'h0, 64'h0, 64'h20, 0);
    tick(); clear_ex();
    n_total++; if (bus.redirect_valid_o !== 1'b0 || bus.flush_o !== 1'b0) $display("FAIL jalr_hit got=%b/%b exp=0/0", bus.redirect_valid_o, bus.flush_o); else n_pass++;
    n_total++; if (mcnt !== 4'(m_mcnt)) $display("FAIL jalr_mcnt got=%0d exp=%0d", mcnt, m_mcnt); else n_pass++;
  endtask

  task automatic test_jal_misalign();
    set_ex(1, 1, 0, 0, 3'd0, 64'h3000, 64'h0, 64'h0, 64'h6, 0);
    tick(); clear_ex();
    n_total++; if (misalign !== 1'b1 || tval !== 64'h3006) $display("FAIL jal_mis got=%b/%h exp=1/3006", misalign, tval); else n_pass++;
    n_total++; if (bus.redirect_valid_o !== 1'b0 || bus.flush_o !== 1'b0) $display("FAIL jal_noredir got=%b/%b exp=0/0", bus.redirect_valid_o, bus.flush_o); else n_pass++;
    tick();
    n_total++; if (misalign !== 1'b0 || tval !== 64'h3006) $display("FAIL jal_pulse got=%b/%h exp=0/3006", misalign, tval); else n_pass++;
  endtask

  task automatic test_priority();
    // jal wins: target 0x4100, no redirect; a jalr reading would mispredict.
    set_ex(1, 1, 1, 0, 3'd0, 64'h4000, 64'h7000, 64'h0, 64'h100, 0);
    tick(); clear_ex();
    n_total++; if (bus.redirect_valid_o !== 1'b0 || misalign !== 1'b0) $display("FAIL prio_jal got=%b/%b exp=0/0", bus.redirect_valid_o, misalign); else n_pass++;
  endtask

  task automatic test_ignore_in_redirect();
    int bc, mc;
    set_ex(1, 0, 0, 1, 3'd1, 64'h6000, 64'd3, 64'd3, 64'h80, 1);
    tick();
    bc = m_bcnt; mc = m_mcnt;
    // Another mispredicting branch stays in EX for the whole redirect, ack cycle included.
    set_ex(1, 0, 0, 1, 3'd0, 64'h7000, 64'd3, 64'd3, 64'h100, 0);
    tick(); tick();
    bus.redirect_ack_i = 1; tick(); bus.redirect_ack_i = 0; clear_ex();
    n_total++; if (bus.redirect_valid_o !== 1'b0 || bus.flush_o !== 1'b0) $display("FAIL ign_state got=%b/%b exp=0/0", bus.redirect_valid_o, bus.flush_o); else n_pass++;
    n_total++; if (bus.redirect_pc_o !== 64'h6004) $display("FAIL ign_rpc got=%h exp=6004", bus.redirect_pc_o); else n_pass++;
    n_total++; if (bcnt !== 4'(bc) || mcnt !== 4'(mc)) $display("FAIL ign_cnt got=%0d/%0d exp=%0d/%0d", bcnt, mcnt, bc, mc); else n_pass++;
  endtask

  task automatic test_reset_mid_redirect();
    set_ex(1, 0, 0, 1, 3'd1, 64'h1000, 64'd1, 64'd1, 64'h40, 1);
    tick(); clear_ex();
    n_total++; if (bus.redirect_valid_o !== 1'b1) $display("FAIL rstmid_pre got=%b exp=1", bus.redirect_valid_o); else n_pass++;
    rst_n = 0;
    #1;
    n_total++; if (bus.redirect_valid_o !== 1'b0 || bus.flush_o !== 1'b0 || bus.redirect_pc_o !== 64'h0) $display("FAIL rstmid_out got=%b/%b/%h exp=0/0/0", bus.redirect_valid_o, bus.flush_o, bus.redirect_pc_o); else n_pass++;
    n_total++; if (bcnt !== 0 || mcnt !== 0 || misalign !== 1'b0 || tval !== 64'h0) $display("FAIL rstmid_misc got=%0d/%0d/%b/%h exp=0/0/0/0", bcnt, mcnt, misalign, tval); else n_pass++;
    model_reset();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    set_ex(1, 0, 0, 1, 3'd0, 64'h1000, 64'd9, 64'd9, -64'sd16, 1);
    repeat (CMAX + 4) tick();
    n_total++; if (bcnt !== 4'(CMAX)) $display("FAIL sat_bcnt got=%0d exp=%0d", bcnt, CMAX); else n_pass++;
    // Taken but mispredicted with misaligned target: counts as mispredict, no redirect.
    set_ex(1, 0, 0, 1, 3'd0, 64'h1000, 64'd9, 64'd9, 64'h2, 0);
    repeat (CMAX + 4) tick();
    clear_ex();
    n_total++; if (mcnt !== 4'(CMAX)) $display("FAIL sat_mcnt got=%0d exp=%0d", mcnt, CMAX); else n_pass++;
    n_total++; if (bus.redirect_valid_o !== 1'b0) $display("FAIL sat_noredir got=%b exp=0", bus.redirect_valid_o); else n_pass++;
  endtask

  function automatic logic [63:0] pick_val();
    case ($urandom_range(0, 4))
      0: return 64'h0;
      1: return 64'h1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int kind;
      logic [63:0] a, b, imm, pc;
      kind = $urandom_range(0, 5);
      a = pick_val(); b = ($urandom_range(0, 2) == 0) ? a : pick_val();
      imm = 64'($signed(32'($urandom_range(0, 127)) - 32'sd64)) * 4;
      if ($urandom_range(0, 5) == 0) imm = imm + 64'($urandom_range(1, 3));
      pc = 64'($urandom_range(0, 16'hffff)) * 4;
      set_ex($urandom_range(0, 3) != 0, kind == 0, kind == 1, kind >= 2,
             3'($urandom_range(0, 7)), pc, a, b, imm, $urandom_range(0, 1) == 1);
      bus.redirect_ack_i = ($urandom_range(0, 2) == 0);
      tick();
      n_total++; if (bus.redirect_valid_o !== m_busy) $display("FAIL rnd%0d_rv got=%b exp=%b", i, bus.redirect_valid_o, m_busy); else n_pass++;
      n_total++; if (m_busy && bus.redirect_pc_o !== m_rpc) $display("FAIL rnd%0d_rpc got=%h exp=%h", i, bus.redirect_pc_o, m_rpc); else n_pass++;
      n_total++; if (bus.flush_o !== m_flush) $display("FAIL rnd%0d_flush got=%b exp=%b", i, bus.flush_o, m_flush); else n_pass++;
      n_total++; if (misalign !== m_mis || tval !== m_tval) $display("FAIL rnd%0d_mis got=%b/%h exp=%b/%h", i, misalign, tval, m_mis, m_tval); else n_pass++;
      n_total++; if (bcnt !== 4'(m_bcnt) || mcnt !== 4'(m_mcnt)) $display("FAIL rnd%0d_cnt got=%0d/%0d exp=%0d/%0d", i, bcnt, mcnt, m_bcnt, m_mcnt); else n_pass++;
      n_total++; if (link !== pc + 64'd4) $display("FAIL rnd%0d_link got=%h exp=%h", i, link, pc + 64'd4); else n_pass++;
    end
    bus.redirect_ack_i = 0;
    clear_ex();
  endtask

  initial begin
    test_reset();
    test_beq_hit();
    test_bne_redirect();
    test_bltu_forward();
    test_jalr();
    test_jal_misalign();
    test_priority();
    test_ignore_in_redirect();
    test_reset_mid_redirect();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bru_resolve.md
Name: bru_resolve

Overview:
- Execute-stage branch resolution unit; the consumer end of the fetch unit's static prediction (backward conditional branch predicted taken, jal followed, jalr followed to 0+imm).
- Evaluates conditions and real targets, detects mispredictions and drives a held redirect/flush handshake back to fetch.
- Also reports misaligned targets and keeps saturating branch/mispredict counters.

Parameters:
- XLEN, 64, operand width
- PC_WIDTH, 64, PC width
- CNT_WIDTH, 32, width of each statistics counter

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- ex_valid_i  input  1  EX holds a valid instruction this cycle
- ex_pc_i  input  PC_WIDTH  PC of EX instruction
- ex_jal_i  input  1  instruction is jal
- ex_jalr_i  input  1  instruction is jalr
- ex_branch_i  input  1  instruction is conditional branch
- ex_funct3_i  input  3  branch condition code
- ex_rs1_i  input  XLEN  rs1 value (forwarded)
- ex_rs2_i  input  XLEN  rs2 value (forwarded)
- ex_imm_i  input  XLEN  sign-extended immediate
- ex_prdt_taken_i  input  1  fetch-stage prediction carried down the pipe
- redirect_ack_i  input  1  fetch accepted redirect
- redirect_valid_o  output  1  redirect request to fetch
- redirect_pc_o  output  PC_WIDTH  corrected fetch PC
- flush_o  output  1  one-cycle kill of IF/ID wrong-path instructions
- link_o  output  XLEN  ex_pc_i+4, combinational, for jal/jalr rd
- misalign_o  output  1  one-cycle pulse, target bit[1:0]!=0
- misalign_tval_o  output  PC_WIDTH  offending target, held until next misalign
- branch_cnt_o  output  CNT_WIDTH  resolved conditional branches
- mispred_cnt_o  output  CNT_WIDTH  mispredictions (branch+jalr)

Behaviour:
- Reset: all outputs except link_o = 0; state IDLE.
- Accept condition: acc = ex_valid_i & (state==IDLE). In REDIRECT, all EX inputs are ignored (wrong path), including in the ack cycle.
- Conditions by funct3:
  - 000 eq, 001 ne.
  - 100 lt signed, 101 ge signed.
  - 110 lt unsigned, 111 ge unsigned.
  - 010/011: not taken.
- Targets (all adds are modulo 2^PC_WIDTH):
  - branch taken / jal: pc+imm.
  - branch not taken: pc+4.
  - jalr: (rs1+imm) with bit0 cleared.
- Misprediction:
  - branch: taken != ex_prdt_taken_i.
  - jalr: real target != (imm with bit0 cleared).
  - jal: never mispredicts.
- Misalign check applies to taken branch, jal and jalr targets with bit[1:0]!=0.
  - Next cycle: misalign_o=1 for one cycle and misalign_tval_o=target.
  - No redirect or flush is issued; counters still update; state stays IDLE.
- States:
  - IDLE: acc & mispredict & !misalign -> REDIRECT. Next cycle: redirect_valid_o=1, redirect_pc_o=real target, flush_o=1 (one cycle only).
  - REDIRECT: redirect_valid_o and redirect_pc_o held stable until redirect_ack_i=1. In the ack cycle the state returns to IDLE; redirect_valid_o drops the following cycle. An ack arriving while redirect_valid_o=0 is ignored.
- Latency: one cycle from the resolving EX cycle to redirect_valid_o/flush_o. Minimum redirect occupancy is one cycle (ack in the first valid cycle).
- Counters (registered, saturating at all-ones, never wrap):
  - branch_cnt_o += acc & ex_branch_i.
  - mispred_cnt_o += acc & mispredict.
- Multiple type flags asserted together: priority jal > jalr > branch.
- Reset asserted mid-REDIRECT: immediate return to IDLE with all outputs cleared; a pending redirect is dropped.

Test Plan:
- Backward beq, pc=0x1000, imm=-16, rs1=rs2=5, prdt=1 -> no redirect, branch_cnt=1, mispred_cnt=0.
- Backward bne, pc=0x1000, imm=-16, rs1=rs2, prdt=1 -> next cycle redirect_valid=1, redirect_pc=0x1004, flush pulse 1 cycle. Hold ack=0 for 3 cycles: outputs stable. Ack -> valid drops next cycle.
- Forward bltu, pc=0x2000, imm=0x40, rs1=1, rs2=0xFFFF...F, prdt=0 -> redirect_pc=0x2040, mispred_cnt=1.
- jalr, rs1=0x8000, imm=0x11 -> target 0x8010 != 0x10 -> redirect 0x8010. jalr rs1=0, imm=0x20 -> no redirect.
- jal, pc=0x3000, imm=6 -> misalign_o pulse, misalign_tval_o=0x3006, no redirect/flush.
- Mispredict, then during REDIRECT a valid mispredicting branch in EX -> ignored (counters unchanged). rst_n low mid-REDIRECT -> all outputs 0 immediately. Preload counters to all-ones (force) -> no wrap.
